// File: rtl/ifu_if.sv
// Fetch-unit bundle: instruction-memory handshake, decode-side instruction
// stream and the execute-stage redirect/stall controls.
interface ifu_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] ins;
    logic [31:0] ins_addr;
    logic        ins_valid;
    logic        jump;
    logic [31:0] jump_addr;
    logic        hold;

    modport master (
        output mem_req, mem_addr, ins, ins_addr, ins_valid,
        input  mem_gnt, mem_rvalid, mem_rdata, jump, jump_addr, hold
    );

    modport slave (
        input  mem_req, mem_addr, ins, ins_addr, ins_valid,
        output mem_gnt, mem_rvalid, mem_rdata, jump, jump_addr, hold
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding word fetch, output register with a
// one-entry skid buffer, decode stall and execute-stage redirect handling.
module ifu #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INS    = 32'h0000_0013
) (
    input  logic  clk,
    input  logic  rst_n,
    ifu_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic        skid_valid_q;
    logic [31:0] skid_ins_q;
    logic [31:0] skid_addr_q;
    logic        out_valid_q;
    logic [31:0] out_ins_q;
    logic [31:0] out_addr_q;

    logic        req;
    logic        fire;
    logic        resp;
    logic        out_free;
    logic [31:0] jump_target;

    assign jump_target = bus.jump_addr & ~32'd3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect while a fetch is in flight must swallow its response (DROP).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (fire) begin
                    state_d = bus.jump ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d = REQ;
                end else if (bus.jump) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.mem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req      = (state_q == REQ) && !skid_valid_q;
        fire     = req && bus.mem_gnt;
        resp     = (state_q == WAIT) && bus.mem_rvalid;
        out_free = !out_valid_q || !bus.hold;
    end

    assign bus.mem_req   = req;
    assign bus.mem_addr  = pc_q;
    assign bus.ins       = out_ins_q;
    assign bus.ins_addr  = out_addr_q;
    assign bus.ins_valid = out_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_ADDR;
            req_addr_q <= RESET_ADDR;
        end else if (bus.jump) begin
            pc_q <= jump_target;
        end else if (fire) begin
            req_addr_q <= pc_q;
            pc_q       <= pc_q + 32'd4;
        end
    end

    // The skid entry is always older than the response arriving with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_ins_q    <= NOP_INS;
            out_addr_q   <= RESET_ADDR;
            skid_valid_q <= 1'b0;
            skid_ins_q   <= NOP_INS;
            skid_addr_q  <= RESET_ADDR;
        end else if (bus.jump) begin
            out_valid_q  <= 1'b0;
            out_ins_q    <= NOP_INS;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_ins_q    <= skid_ins_q;
                out_addr_q   <= skid_addr_q;
                skid_valid_q <= resp;
                if (resp) begin
                    skid_ins_q  <= bus.mem_rdata;
                    skid_addr_q <= req_addr_q;
                end
            end else if (resp) begin
                out_valid_q <= 1'b1;
                out_ins_q   <= bus.mem_rdata;
                out_addr_q  <= req_addr_q;
            end else begin
                out_valid_q <= 1'b0;
                out_ins_q   <= NOP_INS;
            end
        end else if (resp) begin
            skid_valid_q <= 1'b1;
            skid_ins_q   <= bus.mem_rdata;
            skid_addr_q  <= req_addr_q;
        end
    end

    a_pc_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        pc_q[1:0] == 2'b00);

    a_skid_behind_out: assert property (@(posedge clk) disable iff (!rst_n)
        skid_valid_q |-> out_valid_q);

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (req && !bus.mem_gnt && !bus.jump) |=> $stable(pc_q));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && bus.hold && !bus.jump) |=>
            (out_valid_q && $stable(out_ins_q) && $stable(out_addr_q)));
endmodule

// File: tb/tb_ifu.sv
// Randomised bench for ifu: memory responder plus a queue-based model of the
// in-flight fetch and the instructions waiting for decode.
module tb_ifu;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] NOP_INS    = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_if bus ();

    ifu #(.RESET_ADDR(RESET_ADDR), .NOP_INS(NOP_INS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: pc, one in-flight fetch (maybe to be discarded), pending instructions.
    bit          m_started;
    bit          m_outst;
    bit          m_disc;
    logic [31:0] m_pc;
    logic [31:0] m_raddr;
    logic [31:0] m_shown;
    logic [63:0] m_q[$];

    // Memory responder state and knobs.
    bit          mem_pend;
    logic [31:0] mem_a;
    int          mem_cnt;
    int          g_cnt, g_tgt;
    int          g_min, g_max, r_min, r_max;
    logic [31:0] key;
    bit          spurious;

    bit          arm;
    logic [31:0] arm_addr;
    int          hold_cnt;

    logic        s_req, s_vld, s_hold;
    logic [31:0] s_addr, s_ins, s_iaddr;
    logic [31:0] log_addr[$];
    logic [31:0] log_ins[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %08h required %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_log(input string name, input int idx, input logic [31:0] exp_addr);
        if (idx < log_addr.size()) check(name, log_addr[idx], exp_addr);
        else check(name, log_addr.size(), idx + 1);
    endtask

    function automatic void model_reset();
        m_started = 1'b0;
        m_outst   = 1'b0;
        m_disc    = 1'b0;
        m_pc      = RESET_ADDR;
        m_raddr   = RESET_ADDR;
        m_shown   = RESET_ADDR;
        m_q.delete();
    endfunction

    task automatic step(input bit h, input bit j, input logic [31:0] ja, input bit rn);
        logic        gnt, rv, req_d, req_m, hh, ev_vld;
        logic [31:0] rd, addr_d, ev_ins, ev_addr;
        @(negedge clk);
        req_d  = bus.mem_req;
        addr_d = bus.mem_addr;
        if (arm && bus.ins_valid === 1'b1 && bus.ins_addr === arm_addr) begin
            hold_cnt = 6;
            arm      = 1'b0;
        end
        hh = h || (hold_cnt > 0);
        if (hold_cnt > 0) hold_cnt--;
        if (req_d === 1'b1 && g_cnt == 0) g_tgt = $urandom_range(g_max, g_min);
        gnt = (req_d === 1'b1) && (g_cnt >= g_tgt);
        rv  = (mem_pend && mem_cnt == 0) || spurious;
        rd  = (mem_pend && mem_cnt == 0) ? (mem_a ^ key) : $urandom;

        rst_n          = rn;
        bus.hold       = hh;
        bus.jump       = j;
        bus.jump_addr  = ja;
        bus.mem_gnt    = gnt;
        bus.mem_rvalid = rv;
        bus.mem_rdata  = rd;

        req_m   = m_started && !m_outst && (m_q.size() < 2);
        ev_vld  = m_q.size() > 0;
        ev_ins  = ev_vld ? m_q[0][63:32] : NOP_INS;
        ev_addr = ev_vld ? m_q[0][31:0] : m_shown;
        s_req   = bus.mem_req;
        s_addr  = bus.mem_addr;
        s_vld   = bus.ins_valid;
        s_ins   = bus.ins;
        s_iaddr = bus.ins_addr;
        s_hold  = hh;
        check("mem_req", s_req, req_m);
        check("mem_addr", s_addr, m_pc);
        check("ins_valid", s_vld, ev_vld);
        check("ins", s_ins, ev_ins);
        check("ins_addr", s_iaddr, ev_addr);
        if (rn && s_vld === 1'b1 && !hh && !j) begin
            log_addr.push_back(s_iaddr);
            log_ins.push_back(s_ins);
        end

        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else if (j) begin
            m_pc = ja & ~32'd3;
            m_q.delete();
            if (m_outst && rv) m_outst = 1'b0;
            else if (m_outst) m_disc = 1'b1;
            if (req_m && gnt) begin
                m_outst = 1'b1;
                m_disc  = 1'b1;
            end
            m_started = 1'b1;
        end else begin
            if (m_q.size() > 0 && !hh) void'(m_q.pop_front());
            if (m_outst && rv) begin
                if (!m_disc) m_q.push_back({rd, m_raddr});
                m_outst = 1'b0;
                m_disc  = 1'b0;
            end
            if (req_m && gnt) begin
                m_outst = 1'b1;
                m_disc  = 1'b0;
                m_raddr = m_pc;
                m_pc    = m_pc + 32'd4;
            end
            m_started = 1'b1;
        end
        if (m_q.size() > 0) m_shown = m_q[0][31:0];

        if (!rn) begin
            mem_pend = 1'b0;
            g_cnt    = 0;
        end else begin
            if (mem_pend && mem_cnt == 0) mem_pend = 1'b0;
            else if (mem_pend) mem_cnt--;
            if (gnt) begin
                mem_pend = 1'b1;
                mem_a    = addr_d;
                mem_cnt  = $urandom_range(r_max, r_min) - 1;
            end
            if (req_d === 1'b1 && !gnt) g_cnt++;
            else g_cnt = 0;
        end
    endtask

    initial begin
        bit found;
        bit seen;
        logic [31:0] first_addr;

        model_reset();
        mem_pend = 0; mem_cnt = 0; g_cnt = 0; g_tgt = 0;
        g_min = 0; g_max = 0; r_min = 1; r_max = 1;
        key = 32'h0; spurious = 0; arm = 0; arm_addr = 0; hold_cnt = 0;
        bus.hold = 0; bus.jump = 0; bus.jump_addr = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);

        // Zero-wait streaming, with a 6-cycle hold once 0x8 is on the output.
        arm = 1; arm_addr = 32'h8;
        for (int k = 0; k < 40; k++) begin
            step(0, 0, 0, 1);
            if (k == 0) begin
                check("rst_req", s_req, 0);
                check("rst_valid", s_vld, 0);
                check("rst_ins", s_ins, NOP_INS);
                check("rst_ins_addr", s_iaddr, RESET_ADDR);
            end
            if (k == 1) begin
                check("first_req", s_req, 1);
                check("first_addr", s_addr, 32'h0);
            end
            if (k == 2) check("wait_no_req", s_req, 0);
            if (k == 3) begin
                check("first_valid", s_vld, 1);
                check("first_ins_addr", s_iaddr, 32'h0);
            end
            if (k == 4) begin
                check("gap_valid", s_vld, 0);
                check("gap_ins", s_ins, NOP_INS);
            end
            if (k == 5) check("second_ins", s_ins, 32'h4);
            if (s_hold) check("hold_ins_addr", s_iaddr, 32'h8);
            if (s_hold && k >= 9) check("hold_blocks_req", s_req, 0);
        end
        for (int i = 0; i < 8; i++) begin
            expect_log("stream_addr", i, 32'(4 * i));
            if (i < log_ins.size()) check("stream_ins", log_ins[i], 32'(4 * i));
        end

        // Redirect during WAIT with the response two cycles out.
        r_min = 2; r_max = 2;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (mem_pend && mem_cnt > 0 && !m_disc) found = 1;
            else step(0, 0, 0, 1);
        end
        check("reach_wait", found, 1);
        log_addr.delete(); log_ins.delete();
        step(0, 1, 32'h103, 1);
        seen = 0; first_addr = 0;
        for (int k = 0; k < 30; k++) begin
            step(0, 0, 0, 1);
            if (k == 0) check("jump_kills_valid", s_vld, 0);
            if (!seen && s_req === 1'b1) begin
                seen = 1;
                first_addr = s_addr;
            end
        end
        check("jump_first_fetch", first_addr, 32'h100);
        expect_log("jump_first_ins", 0, 32'h100);

        // Redirect in the same cycle as the response.
        r_min = 1; r_max = 1;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (mem_pend && mem_cnt == 0 && !m_disc) found = 1;
            else step(0, 0, 0, 1);
        end
        check("reach_rvalid", found, 1);
        log_addr.delete(); log_ins.delete();
        step(0, 1, 32'h200, 1);
        step(0, 0, 0, 1);
        check("jump_rv_req", s_req, 1);
        check("jump_rv_addr", s_addr, 32'h200);
        repeat (12) step(0, 0, 0, 1);
        expect_log("jump_rv_first", 0, 32'h200);

        // Redirect together with hold on a valid instruction.
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (m_q.size() > 0) found = 1;
            else step(0, 0, 0, 1);
        end
        check("reach_valid", found, 1);
        log_addr.delete(); log_ins.delete();
        step(1, 1, 32'h300, 1);
        step(0, 0, 0, 1);
        check("jump_over_hold", s_vld, 0);
        repeat (12) step(0, 0, 0, 1);
        expect_log("jump_hold_first", 0, 32'h300);

        // Slow memory and pc wrap.
        g_min = 3; g_max = 3; r_min = 4; r_max = 4; key = 32'hDEAD_0000;
        step(0, 1, 32'hFFFF_FFF8, 1);
        log_addr.delete(); log_ins.delete();
        repeat (80) step(0, 0, 0, 1);
        expect_log("wrap_0", 0, 32'hFFFF_FFF8);
        expect_log("wrap_1", 1, 32'hFFFF_FFFC);
        expect_log("wrap_2", 2, 32'h0000_0000);
        expect_log("wrap_3", 3, 32'h0000_0004);
        if (log_ins.size() > 2) check("wrap_ins", log_ins[2], 32'hDEAD_0000);

        // Reset with a full skid, then a stray rvalid while idle.
        g_min = 0; g_max = 0; r_min = 1; r_max = 1; key = 0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_q.size() == 2) found = 1;
            else step(1, 0, 0, 1);
        end
        check("skid_full", found, 1);
        step(1, 0, 0, 0);
        spurious = 1;
        step(0, 0, 0, 1);
        spurious = 0;
        check("rst2_req", s_req, 0);
        check("rst2_addr", s_addr, RESET_ADDR);
        check("rst2_valid", s_vld, 0);
        check("rst2_ins", s_ins, NOP_INS);
        check("rst2_ins_addr", s_iaddr, RESET_ADDR);
        log_addr.delete(); log_ins.delete();
        repeat (10) step(0, 0, 0, 1);
        expect_log("restart_0", 0, 32'h0);
        expect_log("restart_1", 1, 32'h4);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            bit          h, j, rn;
            logic [31:0] ja;
            if (k % 64 == 0) begin
                g_max = $urandom_range(3, 0);
                r_max = $urandom_range(4, 1);
                key   = $urandom;
            end
            h  = $urandom_range(99, 0) < 30;
            j  = $urandom_range(99, 0) < 4;
            rn = $urandom_range(199, 0) != 0;
            ja = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
            step(h, j, ja, rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
